// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: paces instruction-memory accesses and drives the PC,
// IF/ID enable and flush controls, with delivered-instruction and bubble counters.
module fetch_sequencer #(
  parameter int MEM_WAIT    = 1,
  parameter int BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic        StallD,
  output logic        PCEnF,
  output logic        IFIDEnD,
  output logic        FlushD,
  output logic        imem_req,
  output logic [1:0]  fsm_state,
  output logic [31:0] fetch_count,
  output logic [15:0] bubble_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);
  localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] fetch_q, fetch_d;
  logic [15:0] bubble_q, bubble_d;
  logic        complete;
  logic        deliver;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      fetch_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      fetch_q    <= fetch_d;
      bubble_q   <= bubble_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    PCEnF      = 1'b0;
    IFIDEnD    = 1'b0;
    FlushD     = 1'b1;
    imem_req   = 1'b0;
    complete   = 1'b0;
    deliver    = 1'b0;

    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          boot_cnt_d = '0;
          state_d    = S_ISSUE;
        end else begin
          boot_cnt_d = boot_cnt_q + 8'd1;
        end
      end

      S_ISSUE, S_WAIT: begin
        imem_req = 1'b1;
        if (state_q == S_ISSUE) begin
          wait_cnt_d = MEM_WAIT_L;
          complete   = (MEM_WAIT_L == 4'd0);
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          complete   = (wait_cnt_q == 4'd1);
        end

        // A redirect wins everywhere: it either discards a finished fetch or
        // abandons the one in flight, and restarts the access at the target.
        if (PCSrcE) begin
          PCEnF      = 1'b1;
          FlushD     = 1'b1;
          wait_cnt_d = MEM_WAIT_L;
          state_d    = S_ISSUE;
        end else if (complete) begin
          if (StallD) begin
            FlushD  = 1'b0;
            state_d = S_HOLD;
          end else begin
            PCEnF   = 1'b1;
            IFIDEnD = 1'b1;
            FlushD  = 1'b0;
            deliver = 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          FlushD  = !StallD;
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        if (PCSrcE) begin
          PCEnF   = 1'b1;
          FlushD  = 1'b1;
          state_d = S_ISSUE;
        end else if (StallD) begin
          FlushD = 1'b0;
        end else begin
          PCEnF   = 1'b1;
          IFIDEnD = 1'b1;
          FlushD  = 1'b0;
          deliver = 1'b1;
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // Boot-time flushes only keep decode clean; they are not counted as bubbles.
  always_comb begin
    fetch_d  = deliver ? fetch_q + 32'd1 : fetch_q;
    bubble_d = bubble_q;
    if (FlushD && (state_q != S_BOOT) && (bubble_q != 16'hFFFF))
      bubble_d = bubble_q + 16'd1;
  end

  assign fsm_state    = state_q;
  assign fetch_count  = fetch_q;
  assign bubble_count = bubble_q;

endmodule
